// File: rtl/ascon_round_ctrl_if.sv
// rtl/ascon_round_ctrl_if.sv - handshake/control bundle between the round controller and its environment
// Optional abort_i exists only when ASCON_ROUND_ABORT_EN is defined.
interface ascon_round_ctrl_if;
    logic       start_i;
    logic       mode_i;
`ifdef ASCON_ROUND_ABORT_EN
    logic       abort_i;
`endif
    logic [3:0] cpt_i;
    logic       en_cpt_o;
    logic       init_12_o;
    logic       init_6_o;
    logic       perm_en_o;
    logic       first_round_o;
    logic       ready_o;
    logic       done_o;

    modport master (
        output start_i,
        output mode_i,
`ifdef ASCON_ROUND_ABORT_EN
        output abort_i,
`endif
        output cpt_i,
        input  en_cpt_o,
        input  init_12_o,
        input  init_6_o,
        input  perm_en_o,
        input  first_round_o,
        input  ready_o,
        input  done_o
    );

    modport slave (
        input  start_i,
        input  mode_i,
`ifdef ASCON_ROUND_ABORT_EN
        input  abort_i,
`endif
        input  cpt_i,
        output en_cpt_o,
        output init_12_o,
        output init_6_o,
        output perm_en_o,
        output first_round_o,
        output ready_o,
        output done_o
    );
endinterface

// File: rtl/ascon_round_ctrl.sv
// rtl/ascon_round_ctrl.sv - Ascon p12/p6 permutation round sequencer driving an external round counter
// Optional feature macro: ASCON_ROUND_ABORT_EN (adds abort_i, cancels a run in progress).
module ascon_round_ctrl #(
    parameter logic [3:0] LAST_ROUND = 4'd11
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    ascon_round_ctrl_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0] state_q, state_d;
    logic       first_q, first_d;

    logic en_cpt, init_12, init_6, perm_en, first_round, ready, done;
    logic abort;

`ifdef ASCON_ROUND_ABORT_EN
    assign abort = bus.abort_i;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        en_cpt      = 1'b0;
        init_12     = 1'b0;
        init_6      = 1'b0;
        perm_en     = 1'b0;
        first_round = 1'b0;
        ready       = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.start_i) begin
                    en_cpt  = 1'b1;
                    init_12 = ~bus.mode_i;
                    init_6  = bus.mode_i;
                    first_d = 1'b1;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                first_d = 1'b0;
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    perm_en     = 1'b1;
                    first_round = first_q;
                    // Counter values beyond the last round are treated as final so a corrupted count cannot hang us.
                    if (bus.cpt_i >= LAST_ROUND) begin
                        state_d = ST_DONE;
                    end else begin
                        en_cpt = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                first_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= ST_IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

    assign bus.en_cpt_o      = en_cpt;
    assign bus.init_12_o     = init_12;
    assign bus.init_6_o      = init_6;
    assign bus.perm_en_o     = perm_en;
    assign bus.first_round_o = first_round;
    assign bus.ready_o       = ready;
    assign bus.done_o        = done;

endmodule
